// File: rtl/alu_bist_pkg.sv
// Shared widths, vector word layout and FSM encoding for the ALU self-test engine.
// Vector word, MSB first: {last, is_cond, op, a, b, expected}.
package alu_bist_pkg;

  localparam int XLEN       = 32;
  localparam int ALU_OP_MSB = 3;
  localparam int OP_W       = ALU_OP_MSB + 1;
  localparam int VEC_W      = 2 + OP_W + 3 * XLEN;

  localparam int VEC_LAST_BIT = VEC_W - 1;
  localparam int VEC_COND_BIT = VEC_W - 2;
  localparam int VEC_OP_LSB   = 3 * XLEN;
  localparam int VEC_A_LSB    = 2 * XLEN;
  localparam int VEC_B_LSB    = XLEN;
  localparam int VEC_EXP_LSB  = 0;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WAIT  = 3'd1,
    ST_LOAD  = 3'd2,
    ST_CHECK = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/alu_bist_vec_unpack.sv
// Pure field split of one vector ROM word; no state.
module alu_bist_vec_unpack
  import alu_bist_pkg::*;
(
  input  logic [VEC_W-1:0]    vec_data,
  output logic                last,
  output logic                is_cond,
  output logic [ALU_OP_MSB:0] op,
  output logic [XLEN-1:0]     a,
  output logic [XLEN-1:0]     b,
  output logic [XLEN-1:0]     expected
);

  assign last     = vec_data[VEC_LAST_BIT];
  assign is_cond  = vec_data[VEC_COND_BIT];
  assign op       = vec_data[VEC_OP_LSB +: OP_W];
  assign a        = vec_data[VEC_A_LSB +: XLEN];
  assign b        = vec_data[VEC_B_LSB +: XLEN];
  assign expected = vec_data[VEC_EXP_LSB +: XLEN];

endmodule

// File: rtl/alu_bist.sv
// ALU built-in self-test: walks a vector ROM, applies each entry to the ALU and
// checks the result. Handshake: start is a one-cycle request taken only in IDLE/DONE;
// busy covers the run, done holds (with pass/overrun valid) until the next start.
module alu_bist
  import alu_bist_pkg::*;
#(
  parameter int ADDR_W     = 8,
  parameter int VEC_DEPTH  = 256,
  parameter int FAIL_CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic [ADDR_W-1:0]     vec_addr,
  input  logic [VEC_W-1:0]      vec_data,
  output logic [XLEN-1:0]       alu_a,
  output logic [XLEN-1:0]       alu_b,
  output logic [ALU_OP_MSB:0]   alu_op,
  output logic                  alu_is_cond,
  input  logic [XLEN-1:0]       alu_result,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic                  overrun,
  output logic [FAIL_CNT_W-1:0] fail_count,
  output logic [ADDR_W-1:0]     first_fail_idx,
  output logic [XLEN-1:0]       first_fail_res,
  output state_t                dbg_state
);

  state_t state, state_next;

  logic                  first_seen;
  logic                  last_q;
  logic [XLEN-1:0]       expected_q;
  logic                  u_last, u_cond;
  logic [ALU_OP_MSB:0]   u_op;
  logic [XLEN-1:0]       u_a, u_b, u_exp;
  logic                  mismatch, at_end, finish, overrun_nxt;
  logic [FAIL_CNT_W-1:0] fail_count_nxt;

  alu_bist_vec_unpack u_unpack (
    .vec_data (vec_data),
    .last     (u_last),
    .is_cond  (u_cond),
    .op       (u_op),
    .a        (u_a),
    .b        (u_b),
    .expected (u_exp)
  );

  assign dbg_state = state;

  always_comb begin
    mismatch       = (alu_result != expected_q);
    at_end         = (vec_addr == ADDR_W'(VEC_DEPTH - 1));
    finish         = last_q || at_end;
    // A last flag on the final ROM slot is a clean end, not an overrun.
    overrun_nxt    = !last_q && at_end;
    fail_count_nxt = fail_count;
    if (mismatch && (fail_count != '1))
      fail_count_nxt = fail_count + FAIL_CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE, ST_DONE: if (start) state_next = ST_WAIT;
      ST_WAIT:          state_next = ST_LOAD;
      ST_LOAD:          state_next = ST_CHECK;
      ST_CHECK:         state_next = finish ? ST_DONE : ST_WAIT;
      default:          state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vec_addr       <= '0;
      alu_a          <= '0;
      alu_b          <= '0;
      alu_op         <= '0;
      alu_is_cond    <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      overrun        <= 1'b0;
      fail_count     <= '0;
      first_fail_idx <= '0;
      first_fail_res <= '0;
      first_seen     <= 1'b0;
      expected_q     <= '0;
      last_q         <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            vec_addr       <= '0;
            fail_count     <= '0;
            first_fail_idx <= '0;
            first_fail_res <= '0;
            first_seen     <= 1'b0;
            overrun        <= 1'b0;
            pass           <= 1'b0;
            done           <= 1'b0;
            busy           <= 1'b1;
          end
        end
        ST_LOAD: begin
          alu_a       <= u_a;
          alu_b       <= u_b;
          alu_op      <= u_op;
          alu_is_cond <= u_cond;
          expected_q  <= u_exp;
          last_q      <= u_last;
        end
        ST_CHECK: begin
          fail_count <= fail_count_nxt;
          if (mismatch && !first_seen) begin
            first_fail_idx <= vec_addr;
            first_fail_res <= alu_result;
            first_seen     <= 1'b1;
          end
          if (finish) begin
            overrun <= overrun_nxt;
            busy    <= 1'b0;
            done    <= 1'b1;
            pass    <= (fail_count_nxt == '0) && !overrun_nxt;
          end else begin
            vec_addr <= vec_addr + ADDR_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_bist.sv
// Scoreboard bench for alu_bist: three instances (default, short ROM, narrow fail
// counter), each with a registered ROM and a small behavioural ALU.
module tb_alu_bist;
  import alu_bist_pkg::*;

  localparam int EXP_W = 1 + 1 + 16 + 8 + 32 + 8 + 8;
  localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_AND = 4'd2, OP_OR = 4'd3, OP_XOR = 4'd4;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  int sel = 0;
  int start_cyc = 0;
  logic [EXP_W-1:0] exp_q[$];

  function automatic logic [XLEN-1:0] alu_model(input logic [ALU_OP_MSB:0] op, input logic c,
                                                input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    if (c) return (op == 4'd0) ? XLEN'(a == b) : XLEN'(a < b);
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      default: return a ^ b;
    endcase
  endfunction

  function automatic logic [VEC_W-1:0] mkvec(input logic last, input logic c, input logic [3:0] op,
                                             input logic [31:0] a, input logic [31:0] b, input logic [31:0] e);
    return {last, c, op, a, b, e};
  endfunction

  // instance m: default parameters
  logic start_m, alu_is_cond_m, busy_m, done_m, pass_m, overrun_m;
  logic [7:0] vec_addr_m, ffi_m;
  logic [VEC_W-1:0] vec_data_m;
  logic [XLEN-1:0] alu_a_m, alu_b_m, alu_result_m, ffr_m;
  logic [ALU_OP_MSB:0] alu_op_m;
  logic [15:0] fail_count_m;
  state_t st_m;
  logic [VEC_W-1:0] rom_m[256];
  always @(posedge clk) vec_data_m <= rom_m[vec_addr_m];
  assign alu_result_m = alu_model(alu_op_m, alu_is_cond_m, alu_a_m, alu_b_m);

  alu_bist dut_m (
    .clk(clk), .rst_n(rst_n), .start(start_m), .vec_addr(vec_addr_m), .vec_data(vec_data_m),
    .alu_a(alu_a_m), .alu_b(alu_b_m), .alu_op(alu_op_m), .alu_is_cond(alu_is_cond_m),
    .alu_result(alu_result_m), .busy(busy_m), .done(done_m), .pass(pass_m), .overrun(overrun_m),
    .fail_count(fail_count_m), .first_fail_idx(ffi_m), .first_fail_res(ffr_m), .dbg_state(st_m)
  );

  // instance o: 4-entry ROM
  logic start_o, alu_is_cond_o, busy_o, done_o, pass_o, overrun_o;
  logic [7:0] vec_addr_o, ffi_o;
  logic [VEC_W-1:0] vec_data_o;
  logic [XLEN-1:0] alu_a_o, alu_b_o, alu_result_o, ffr_o;
  logic [ALU_OP_MSB:0] alu_op_o;
  logic [15:0] fail_count_o;
  state_t st_o;
  logic [VEC_W-1:0] rom_o[256];
  always @(posedge clk) vec_data_o <= rom_o[vec_addr_o];
  assign alu_result_o = alu_model(alu_op_o, alu_is_cond_o, alu_a_o, alu_b_o);

  alu_bist #(.VEC_DEPTH(4)) dut_o (
    .clk(clk), .rst_n(rst_n), .start(start_o), .vec_addr(vec_addr_o), .vec_data(vec_data_o),
    .alu_a(alu_a_o), .alu_b(alu_b_o), .alu_op(alu_op_o), .alu_is_cond(alu_is_cond_o),
    .alu_result(alu_result_o), .busy(busy_o), .done(done_o), .pass(pass_o), .overrun(overrun_o),
    .fail_count(fail_count_o), .first_fail_idx(ffi_o), .first_fail_res(ffr_o), .dbg_state(st_o)
  );

  // instance s: 2-bit fail counter
  logic start_s, alu_is_cond_s, busy_s, done_s, pass_s, overrun_s;
  logic [7:0] vec_addr_s, ffi_s;
  logic [VEC_W-1:0] vec_data_s;
  logic [XLEN-1:0] alu_a_s, alu_b_s, alu_result_s, ffr_s;
  logic [ALU_OP_MSB:0] alu_op_s;
  logic [1:0] fail_count_s;
  state_t st_s;
  logic [VEC_W-1:0] rom_s[256];
  always @(posedge clk) vec_data_s <= rom_s[vec_addr_s];
  assign alu_result_s = alu_model(alu_op_s, alu_is_cond_s, alu_a_s, alu_b_s);

  alu_bist #(.FAIL_CNT_W(2)) dut_s (
    .clk(clk), .rst_n(rst_n), .start(start_s), .vec_addr(vec_addr_s), .vec_data(vec_data_s),
    .alu_a(alu_a_s), .alu_b(alu_b_s), .alu_op(alu_op_s), .alu_is_cond(alu_is_cond_s),
    .alu_result(alu_result_s), .busy(busy_s), .done(done_s), .pass(pass_s), .overrun(overrun_s),
    .fail_count(fail_count_s), .first_fail_idx(ffi_s), .first_fail_res(ffr_s), .dbg_state(st_s)
  );

  // observation mux for the instance under test
  logic obs_done, obs_pass, obs_ovr;
  logic [15:0] obs_fc;
  logic [7:0] obs_ffi, obs_addr;
  logic [31:0] obs_ffr;
  always_comb begin
    obs_done = done_m; obs_pass = pass_m; obs_ovr = overrun_m; obs_fc = fail_count_m;
    obs_ffi = ffi_m; obs_ffr = ffr_m; obs_addr = vec_addr_m;
    if (sel == 1) begin
      obs_done = done_o; obs_pass = pass_o; obs_ovr = overrun_o; obs_fc = fail_count_o;
      obs_ffi = ffi_o; obs_ffr = ffr_o; obs_addr = vec_addr_o;
    end else if (sel == 2) begin
      obs_done = done_s; obs_pass = pass_s; obs_ovr = overrun_s; obs_fc = {14'b0, fail_count_s};
      obs_ffi = ffi_s; obs_ffr = ffr_s; obs_addr = vec_addr_s;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // scoreboard monitor: one expected record per completed run
  logic done_prev = 1'b0;
  logic [EXP_W-1:0] mon_e;
  always @(negedge clk) begin
    if (rst_n && obs_done && !done_prev) begin
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done: got done with no expected run (sel %0d)", sel);
      end else begin
        mon_e = exp_q.pop_front();
        check("pass",           64'(obs_pass),       64'(mon_e[73]));
        check("overrun",        64'(obs_ovr),        64'(mon_e[72]));
        check("fail_count",     64'(obs_fc),         64'(mon_e[71:56]));
        check("first_fail_idx", 64'(obs_ffi),        64'(mon_e[55:48]));
        check("first_fail_res", 64'(obs_ffr),        64'(mon_e[47:16]));
        check("vec_addr",       64'(obs_addr),       64'(mon_e[15:8]));
        check("latency",        64'(cyc - start_cyc), 64'(mon_e[7:0]));
      end
    end
    done_prev = obs_done;
  end

  // driver tasks
  task automatic push_exp(input logic p, input logic ov, input logic [15:0] fc, input logic [7:0] ffi,
                          input logic [31:0] ffr, input logic [7:0] addr, input logic [7:0] lat);
    exp_q.push_back({p, ov, fc, ffi, ffr, addr, lat});
  endtask

  task automatic set_start(input logic v);
    case (sel)
      1:       start_o = v;
      2:       start_s = v;
      default: start_m = v;
    endcase
  endtask

  task automatic pulse_start();
    @(negedge clk);
    set_start(1'b1);
    start_cyc = cyc;
    @(negedge clk);
    set_start(1'b0);
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (!obs_done && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!obs_done) begin
      errors++;
      $display("FAIL %s_timeout: got no done after %0d cycles, required done", name, n);
    end
    @(negedge clk);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_status"}, {busy_m, done_m, pass_m, overrun_m, fail_count_m, ffi_m, vec_addr_m}, 64'd0);
    check({tag, "_ffr"},    64'(ffr_m), 64'd0);
    check({tag, "_alu_a"},  64'(alu_a_m), 64'd0);
    check({tag, "_alu_b"},  64'(alu_b_m), 64'd0);
    check({tag, "_alu_op"}, 64'({alu_is_cond_m, alu_op_m}), 64'd0);
    check({tag, "_state"},  64'(st_m), 64'(ST_IDLE));
  endtask

  task automatic load_rom_m_ok();
    rom_m[0] = mkvec(1'b0, 1'b0, OP_ADD, 32'd5, 32'd3, 32'd8);
    rom_m[1] = mkvec(1'b0, 1'b0, OP_SUB, 32'd5, 32'd3, 32'd2);
    rom_m[2] = mkvec(1'b1, 1'b0, OP_AND, 32'hF0, 32'h3C, 32'h30);
  endtask

  initial begin
    rst_n = 1'b0;
    start_m = 1'b0; start_o = 1'b0; start_s = 1'b0;
    for (int i = 0; i < 256; i++) begin
      rom_m[i] = '0; rom_o[i] = '0; rom_s[i] = '0;
    end
    repeat (3) @(negedge clk);
    check_zero("por");
    rst_n = 1'b1;

    // entry 1 expected value corrupted to 7 (ALU gives 2)
    load_rom_m_ok();
    rom_m[1] = mkvec(1'b0, 1'b0, OP_SUB, 32'd5, 32'd3, 32'd7);
    push_exp(1'b0, 1'b0, 16'd1, 8'd1, 32'd2, 8'd2, 8'd10);
    pulse_start();
    wait_done("corrupt1");

    // restart from DONE with a clean ROM: counters must clear
    load_rom_m_ok();
    push_exp(1'b1, 1'b0, 16'd0, 8'd0, 32'd0, 8'd2, 8'd10);
    pulse_start();
    wait_done("clean");

    // start pulsed again mid-run is ignored
    push_exp(1'b1, 1'b0, 16'd0, 8'd0, 32'd0, 8'd2, 8'd10);
    pulse_start();
    repeat (2) @(negedge clk);
    start_m = 1'b1;
    @(negedge clk);
    start_m = 1'b0;
    wait_done("busy_restart");

    // failures on entries 0 and 2, entry 2 also last
    rom_m[0] = mkvec(1'b0, 1'b0, OP_ADD, 32'd5, 32'd3, 32'd9);
    rom_m[2] = mkvec(1'b1, 1'b0, OP_AND, 32'hF0, 32'h3C, 32'h31);
    push_exp(1'b0, 1'b0, 16'd2, 8'd0, 32'd8, 8'd2, 8'd10);
    pulse_start();
    wait_done("fail_and_last");

    // reset while checking entry 1
    load_rom_m_ok();
    pulse_start();
    while (cyc != start_cyc + 6) @(negedge clk);
    check("mid_state", 64'(st_m), 64'(ST_CHECK));
    check("mid_addr",  64'(vec_addr_m), 64'd1);
    rst_n = 1'b0;
    @(negedge clk);
    check_zero("midrst");
    rst_n = 1'b1;
    push_exp(1'b1, 1'b0, 16'd0, 8'd0, 32'd0, 8'd2, 8'd10);
    pulse_start();
    wait_done("after_reset");

    // 4-entry ROM, no last flag in range; entry 4 must never be reached
    sel = 1;
    for (int i = 0; i < 4; i++)
      rom_o[i] = mkvec(1'b0, 1'b0, OP_ADD, 32'(i), 32'd1, 32'(i + 1));
    rom_o[4] = mkvec(1'b1, 1'b0, OP_ADD, 32'd0, 32'd0, 32'd0);
    @(negedge clk);
    push_exp(1'b0, 1'b1, 16'd0, 8'd0, 32'd0, 8'd3, 8'd13);
    pulse_start();
    wait_done("overrun");

    // five failing vectors against a 2-bit counter
    sel = 2;
    rom_s[0] = mkvec(1'b0, 1'b0, OP_ADD, 32'd1,  32'd1,  32'd0);
    rom_s[1] = mkvec(1'b0, 1'b0, OP_SUB, 32'd9,  32'd4,  32'd4);
    rom_s[2] = mkvec(1'b0, 1'b0, OP_OR,  32'h0F, 32'hF0, 32'd0);
    rom_s[3] = mkvec(1'b0, 1'b1, 4'd0,   32'd7,  32'd7,  32'd0);
    rom_s[4] = mkvec(1'b1, 1'b0, OP_XOR, 32'd6,  32'd3,  32'd0);
    @(negedge clk);
    push_exp(1'b0, 1'b0, 16'd3, 8'd0, 32'd2, 8'd4, 8'd16);
    pulse_start();
    wait_done("saturate");

    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
